// File: rtl/config_tx_pkg.sv
// config_tx_pkg
// Shared definitions for the serial configuration transmitter:
//   - state_e          : FSM state encoding (also exported as a debug port)
//   - calc_bit_cycles  : CLOCK cycles per serial bit from the two periods
//   - cnt_width        : register width able to hold 0..n-1
//   - lowest_set       : index of the lowest set bit of a 16-bit mask
package config_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_NEXT  = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Truncating division: a partial cycle is dropped, so a bit is never
  // longer than the nominal bit period.
  function automatic int calc_bit_cycles(input int clk_ps, input int bit_ns);
    return (bit_ns * 1000) / clk_ps;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Scan from the top down so the last hit is the lowest set bit.
  function automatic logic [3:0] lowest_set(input logic [15:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = i[3:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/config_tx_bitgen.sv
// config_tx_bitgen
// Bit-timing generator. While run_i is high it counts 0..BIT_CYCLES-1 once
// per serial bit; the first BIT_CYCLES/2 cycles are the low phase of the
// serial clock, the rest the high phase.
// Ports:
//   clk_i     : system clock
//   rst_ni    : synchronous active-low reset
//   run_i     : count enable; counter is held at zero while low
//   tx_clk_o  : serial clock phase (0 while not running)
//   bit_end_o : high on the last cycle of each bit
module config_tx_bitgen
  import config_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 19
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic tx_clk_o,
  output logic bit_end_o
);

  localparam int CW = cnt_width(BIT_CYCLES);
  localparam logic [CW-1:0] LAST_C = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] LOW_C  = CW'(BIT_CYCLES / 2);

  logic [CW-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (!run_i || (cyc_q == LAST_C)) begin
      cyc_d = '0;
    end else begin
      cyc_d = cyc_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign tx_clk_o  = run_i && (cyc_q >= LOW_C);
  assign bit_end_o = run_i && (cyc_q == LAST_C);

endmodule

// File: rtl/config_tx_mc.sv
// config_tx_mc
// Multi-channel serial configuration transmitter. On a START rising edge the
// channel mask, bit count and configuration word are latched; each masked
// channel (lowest index first) then gets an idle gap of LINE_PERIOD cycles
// followed by a burst of NBITS bits on the shared TX_CLK/TX_DAT pair with its
// own TX_OE bit raised. A single TX_END pulse closes the whole transfer.
// Ports:
//   CLOCK, RESET_N : clock and synchronous active-low reset
//   START          : transfer request (rising edge, ignored while BUSY)
//   CH_MASK        : channels to configure
//   NBITS          : bits per burst (0 or >C_NO_CFG_BITS means C_NO_CFG_BITS)
//   INPUT          : configuration word, lowest NBITS bits sent
//   LINE_PERIOD    : gap in cycles before each burst
//   BUSY, TX_END   : transfer status and completion pulse
//   TX_CLK, TX_DAT : shared serial clock and data
//   TX_OE          : per-channel output enable (one-hot during a burst)
//   CH_IDX         : channel being served, 0 when idle
//   DBG_STATE      : current FSM state
// Handshake: START is a level input whose rising edge is the request; there
// is no acknowledge other than BUSY rising on the following cycle, and any
// edge seen while BUSY is dropped rather than queued.
module config_tx_mc
  import config_tx_pkg::*;
#(
  parameter int CLOCK_PERIOD_PS = 20833,
  parameter int BIT_PERIOD_NS   = 400,
  parameter int C_NO_CFG_BITS   = 24,
  parameter int C_NO_CHANNELS   = 4,
  parameter int C_MSB_FIRST     = 1,
  localparam int NB_W           = $clog2(C_NO_CFG_BITS + 1)
) (
  input  logic                     CLOCK,
  input  logic                     RESET_N,
  input  logic                     START,
  input  logic [C_NO_CHANNELS-1:0] CH_MASK,
  input  logic [NB_W-1:0]          NBITS,
  input  logic [C_NO_CFG_BITS-1:0] INPUT,
  input  logic [15:0]              LINE_PERIOD,
  output logic                     BUSY,
  output logic                     TX_END,
  output logic                     TX_CLK,
  output logic                     TX_DAT,
  output logic [C_NO_CHANNELS-1:0] TX_OE,
  output logic [3:0]               CH_IDX,
  output state_e                   DBG_STATE
);

  localparam int BIT_CYCLES = calc_bit_cycles(CLOCK_PERIOD_PS, BIT_PERIOD_NS);
  localparam int BC_W       = cnt_width(C_NO_CFG_BITS);
  localparam logic [NB_W-1:0] MAX_NB = NB_W'(C_NO_CFG_BITS);

  if (BIT_CYCLES < 2) begin : g_bad_bit_cycles
    $error("config_tx_mc: BIT_CYCLES must be at least 2");
  end
  if ((C_NO_CHANNELS < 1) || (C_NO_CHANNELS > 16)) begin : g_bad_channels
    $error("config_tx_mc: C_NO_CHANNELS must be in 1..16");
  end

  state_e                   state_q, state_d;
  logic                     start_q;
  logic [C_NO_CHANNELS-1:0] mask_q, mask_d;
  logic [NB_W-1:0]          nbits_q, nbits_d;
  logic [C_NO_CFG_BITS-1:0] word_q, word_d;
  logic [3:0]               ch_q, ch_d;
  logic [15:0]              gap_q, gap_d;
  logic [BC_W-1:0]          bit_q, bit_d;

  logic                     start_rise;
  logic [NB_W-1:0]          nbits_eff;
  logic [C_NO_CHANNELS-1:0] ch_onehot;
  logic [C_NO_CHANNELS-1:0] mask_rem;
  logic [15:0]              mask16;
  logic [15:0]              rem16;
  logic                     shifting;
  logic                     bg_clk;
  logic                     bg_bit_end;
  logic                     last_bit;
  logic [NB_W-1:0]          dat_idx;
  logic [C_NO_CFG_BITS-1:0] word_shifted;

  assign start_rise = START && !start_q;
  assign nbits_eff  = ((NBITS == '0) || (NBITS > MAX_NB)) ? MAX_NB : NBITS;
  assign ch_onehot  = C_NO_CHANNELS'(1) << ch_q;
  assign mask_rem   = mask_q & ~ch_onehot;
  assign shifting   = (state_q == ST_SHIFT);
  assign last_bit   = ((NB_W'(bit_q) + NB_W'(1)) == nbits_q);

  always_comb begin
    mask16 = '0;
    rem16  = '0;
    mask16[C_NO_CHANNELS-1:0] = mask_q;
    rem16[C_NO_CHANNELS-1:0]  = mask_rem;
  end

  config_tx_bitgen #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bitgen (
    .clk_i    (CLOCK),
    .rst_ni   (RESET_N),
    .run_i    (shifting),
    .tx_clk_o (bg_clk),
    .bit_end_o(bg_bit_end)
  );

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    nbits_d = nbits_q;
    word_d  = word_q;
    ch_d    = ch_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_LOAD;
          mask_d  = CH_MASK;
          nbits_d = nbits_eff;
          word_d  = INPUT;
        end
      end
      ST_LOAD: begin
        gap_d = '0;
        bit_d = '0;
        if (mask_q == '0) begin
          state_d = ST_DONE;
        end else begin
          ch_d    = lowest_set(mask16);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        // A zero LINE_PERIOD still spends one cycle here.
        if ((17'(gap_q) + 17'd1) >= 17'(LINE_PERIOD)) begin
          gap_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          gap_d = gap_q + 16'd1;
        end
      end
      ST_SHIFT: begin
        if (bg_bit_end) begin
          if (last_bit) begin
            bit_d   = '0;
            state_d = ST_NEXT;
          end else begin
            bit_d = bit_q + BC_W'(1);
          end
        end
      end
      ST_NEXT: begin
        mask_d = mask_rem;
        if (mask_rem == '0) begin
          state_d = ST_DONE;
        end else begin
          ch_d    = lowest_set(rem16);
          state_d = ST_GAP;
        end
      end
      ST_DONE: begin
        mask_d  = '0;
        ch_d    = '0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      // Primed high so a START already asserted across reset is not an edge.
      start_q <= 1'b1;
      mask_q  <= '0;
      nbits_q <= '0;
      word_q  <= '0;
      ch_q    <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= START;
      mask_q  <= mask_d;
      nbits_q <= nbits_d;
      word_q  <= word_d;
      ch_q    <= ch_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
    end
  end

  // Bit selection: MSB-first walks down from bit NBITS-1. The bit counter
  // only advances at the end of a bit, so TX_DAT moves exactly when TX_CLK
  // drops back to its low phase.
  assign dat_idx      = (C_MSB_FIRST != 0) ? (nbits_q - NB_W'(1) - NB_W'(bit_q))
                                           : NB_W'(bit_q);
  assign word_shifted = word_q >> dat_idx;

  assign BUSY      = (state_q == ST_LOAD) || (state_q == ST_GAP) ||
                     (state_q == ST_SHIFT) || (state_q == ST_NEXT);
  assign TX_END    = (state_q == ST_DONE);
  assign TX_CLK    = shifting && bg_clk;
  assign TX_DAT    = shifting && word_shifted[0];
  assign TX_OE     = shifting ? ch_onehot : '0;
  assign CH_IDX    = BUSY ? ch_q : 4'd0;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_config_tx_mc.sv
`timescale 1ns/1ps
module tb_config_tx_mc;
  import config_tx_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        rst_n;
  logic        start_m, start_l;
  logic [3:0]  ch_mask;
  logic [4:0]  nbits;
  logic [23:0] word;
  logic [15:0] line_period;

  logic        busy_m, end_m, tclk_m, tdat_m;
  logic [3:0]  oe_m, ch_m;
  state_e      st_m;
  logic        busy_l, end_l, tclk_l, tdat_l;
  logic [3:0]  oe_l, ch_l;
  state_e      st_l;

  logic        use_lsb;
  logic        mon_busy, mon_end, mon_clk, mon_dat;
  logic [3:0]  mon_oe, mon_ch;
  state_e      mon_state;

  assign mon_busy  = use_lsb ? busy_l : busy_m;
  assign mon_end   = use_lsb ? end_l  : end_m;
  assign mon_clk   = use_lsb ? tclk_l : tclk_m;
  assign mon_dat   = use_lsb ? tdat_l : tdat_m;
  assign mon_oe    = use_lsb ? oe_l   : oe_m;
  assign mon_ch    = use_lsb ? ch_l   : ch_m;
  assign mon_state = use_lsb ? st_l   : st_m;

  config_tx_mc u_dut_msb (
    .CLOCK(clk), .RESET_N(rst_n), .START(start_m), .CH_MASK(ch_mask),
    .NBITS(nbits), .INPUT(word), .LINE_PERIOD(line_period),
    .BUSY(busy_m), .TX_END(end_m), .TX_CLK(tclk_m), .TX_DAT(tdat_m),
    .TX_OE(oe_m), .CH_IDX(ch_m), .DBG_STATE(st_m)
  );

  config_tx_mc #(.C_MSB_FIRST(0)) u_dut_lsb (
    .CLOCK(clk), .RESET_N(rst_n), .START(start_l), .CH_MASK(ch_mask),
    .NBITS(nbits), .INPUT(word), .LINE_PERIOD(line_period),
    .BUSY(busy_l), .TX_END(end_l), .TX_CLK(tclk_l), .TX_DAT(tdat_l),
    .TX_OE(oe_l), .CH_IDX(ch_l), .DBG_STATE(st_l)
  );

  // ---------------- scoreboard state ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic       exp_q[$];
  logic       cap_bits[$];
  int         cap_gaps[$];
  int         cap_lens[$];
  logic [3:0] cap_oe[$];
  logic [3:0] cap_ch[$];
  int cap_end_cnt, cap_end_cyc, cap_busy_rises, cap_dat_viol;
  int cap_end_busy, cap_busy_drop;
  logic cap_busy_first;

  // ---------------- driver tasks ----------------
  task automatic do_start(input bit lsb);
    use_lsb = lsb;
    @(negedge clk);
    start_m = 1'b0;
    start_l = 1'b0;
    @(negedge clk);
    @(negedge clk);
    if (lsb) start_l = 1'b1;
    else     start_m = 1'b1;
  endtask

  // Records what the selected DUT does for up to max_cycles cycles after the
  // START edge; stops at the first TX_END unless run_full is set.
  task automatic capture(input int max_cycles, input bit run_full);
    logic prev_clk, prev_dat, prev_busy;
    logic [3:0] prev_oe;
    int gap_run, len_run;
    cap_bits.delete(); cap_gaps.delete(); cap_lens.delete();
    cap_oe.delete(); cap_ch.delete();
    cap_end_cnt = 0; cap_end_cyc = -1; cap_busy_rises = 0; cap_dat_viol = 0;
    cap_end_busy = 0; cap_busy_drop = 0; cap_busy_first = 1'b0;
    prev_clk = 1'b0; prev_dat = 1'b0; prev_busy = 1'b0; prev_oe = 4'd0;
    gap_run = 0; len_run = 0;
    for (int c = 1; c <= max_cycles; c++) begin
      @(negedge clk);
      if (c == 1) cap_busy_first = mon_busy;
      if (mon_busy && !prev_busy) cap_busy_rises++;
      if (mon_state == ST_GAP) gap_run++;
      if (mon_oe != 4'd0) begin
        if (prev_oe == 4'd0) begin
          cap_gaps.push_back(gap_run);
          gap_run = 0;
          cap_oe.push_back(mon_oe);
          cap_ch.push_back(mon_ch);
          len_run = 0;
        end
        len_run++;
      end else if (prev_oe != 4'd0) begin
        cap_lens.push_back(len_run);
      end
      if (mon_clk && !prev_clk) cap_bits.push_back(mon_dat);
      if (mon_clk && prev_clk && (mon_dat !== prev_dat)) cap_dat_viol++;
      if (mon_end) begin
        cap_end_cnt++;
        if (cap_end_cyc < 0) cap_end_cyc = c;
        if (mon_busy) cap_end_busy++;
      end else if ((cap_end_cyc < 0) && !mon_busy) begin
        cap_busy_drop++;
      end
      prev_clk = mon_clk; prev_dat = mon_dat; prev_busy = mon_busy; prev_oe = mon_oe;
      if (!run_full && mon_end) break;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; start_m = 1'b1; start_l = 1'b1; use_lsb = 1'b0;
    ch_mask = 4'b1111; nbits = 5'd24; word = 24'h123456; line_period = 16'd3;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy_m, end_m, tclk_m, tdat_m, oe_m, ch_m} !== 12'd0) begin
      n_bad++; $display("FAIL reset_outputs_msb: got %b want 0", {busy_m, end_m, tclk_m, tdat_m, oe_m, ch_m});
    end
    n_cmp++;
    if ({busy_l, end_l, tclk_l, tdat_l, oe_l, ch_l} !== 12'd0) begin
      n_bad++; $display("FAIL reset_outputs_lsb: got %b want 0", {busy_l, end_l, tclk_l, tdat_l, oe_l, ch_l});
    end
    n_cmp++;
    if (st_m !== ST_IDLE) begin
      n_bad++; $display("FAIL reset_state: got %0d want %0d", st_m, ST_IDLE);
    end
    // START stays high through reset release: must not be seen as an edge.
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({busy_m, busy_l} !== 2'b00) begin
      n_bad++; $display("FAIL reset_start_primed: busy got %b want 00", {busy_m, busy_l});
    end
  endtask

  task automatic test_single();
    logic [23:0] hand8_word;
    ch_mask = 4'b0001; nbits = 5'd24; word = 24'hAEC9EC; line_period = 16'd4000;
    do_start(1'b0);
    capture(6000, 1'b0);
    n_cmp++;
    if (cap_busy_first !== 1'b1) begin
      n_bad++; $display("FAIL single_busy_next_cycle: got %b want 1", cap_busy_first);
    end
    n_cmp++;
    if (cap_end_cyc !== 4459) begin
      n_bad++; $display("FAIL single_end_cycle: got %0d want 4459", cap_end_cyc);
    end
    n_cmp++;
    if ((cap_gaps.size() !== 1) || (cap_lens.size() !== 1)) begin
      n_bad++; $display("FAIL single_burst_count: got %0d/%0d want 1/1", cap_gaps.size(), cap_lens.size());
    end else begin
      n_cmp++;
      if (cap_gaps[0] !== 4000) begin
        n_bad++; $display("FAIL single_gap: got %0d want 4000", cap_gaps[0]);
      end
      n_cmp++;
      if (cap_lens[0] !== 456) begin
        n_bad++; $display("FAIL single_len: got %0d want 456", cap_lens[0]);
      end
      n_cmp++;
      if ((cap_oe[0] !== 4'b0001) || (cap_ch[0] !== 4'd0)) begin
        n_bad++; $display("FAIL single_oe_ch: got %b/%0d want 0001/0", cap_oe[0], cap_ch[0]);
      end
    end
    // Hand-listed leading bits: 1,0,1,0,1,1,1,0
    hand8_word = 24'hAE0000;
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(hand8_word[23 - i]);
    for (int i = 16; i < 24; i++) exp_q.push_back(word[23 - i]);
    n_cmp++;
    if (cap_bits.size() !== 24) begin
      n_bad++; $display("FAIL single_bit_count: got %0d want 24", cap_bits.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (cap_bits[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL single_bit%0d: got %b want %b", i, cap_bits[i], exp_q[i]);
        end
      end
      for (int i = 16; i < 24; i++) begin
        n_cmp++;
        if (cap_bits[i] !== exp_q[i - 8]) begin
          n_bad++; $display("FAIL single_bit%0d: got %b want %b", i, cap_bits[i], exp_q[i - 8]);
        end
      end
    end
    n_cmp++;
    if ((cap_dat_viol !== 0) || (cap_end_busy !== 0) || (cap_busy_drop !== 0)) begin
      n_bad++; $display("FAIL single_timing: dat_viol %0d end_busy %0d busy_drop %0d want 0/0/0",
                        cap_dat_viol, cap_end_busy, cap_busy_drop);
    end
  endtask

  task automatic test_two_channels();
    logic [47:0] got;
    ch_mask = 4'b0101; nbits = 5'd24; word = 24'hAEC9EC; line_period = 16'd4000;
    do_start(1'b0);
    capture(10000, 1'b0);
    n_cmp++;
    if ((cap_end_cnt !== 1) || (cap_end_cyc !== 8916)) begin
      n_bad++; $display("FAIL two_end: got cnt %0d cyc %0d want 1/8916", cap_end_cnt, cap_end_cyc);
    end
    n_cmp++;
    if (cap_ch.size() !== 2) begin
      n_bad++; $display("FAIL two_burst_count: got %0d want 2", cap_ch.size());
    end else begin
      n_cmp++;
      if ({cap_ch[0], cap_ch[1], cap_oe[0], cap_oe[1]} !== {4'd0, 4'd2, 4'b0001, 4'b0100}) begin
        n_bad++; $display("FAIL two_ch_oe: got %0d,%0d %b,%b want 0,2 0001,0100",
                          cap_ch[0], cap_ch[1], cap_oe[0], cap_oe[1]);
      end
      n_cmp++;
      if ((cap_gaps[1] !== 4000) || (cap_lens[0] !== 456) || (cap_lens[1] !== 456)) begin
        n_bad++; $display("FAIL two_gap_len: got gap %0d len %0d,%0d want 4000 456,456",
                          cap_gaps[1], cap_lens[0], cap_lens[1]);
      end
    end
    n_cmp++;
    if (cap_bits.size() !== 48) begin
      n_bad++; $display("FAIL two_bit_count: got %0d want 48", cap_bits.size());
    end else begin
      for (int i = 0; i < 48; i++) got[47 - i] = cap_bits[i];
      n_cmp++;
      if (got !== 48'hAEC9EC_AEC9EC) begin
        n_bad++; $display("FAIL two_bits: got %h want aec9ecaec9ec", got);
      end
    end
  endtask

  task automatic test_empty_mask();
    ch_mask = 4'b0000; nbits = 5'd24; word = 24'hAEC9EC; line_period = 16'd4000;
    do_start(1'b0);
    capture(20, 1'b0);
    n_cmp++;
    if ((cap_end_cnt !== 1) || (cap_end_cyc < 1) || (cap_end_cyc > 3)) begin
      n_bad++; $display("FAIL empty_end: got cnt %0d cyc %0d want 1 within 3", cap_end_cnt, cap_end_cyc);
    end
    n_cmp++;
    if (cap_oe.size() !== 0) begin
      n_bad++; $display("FAIL empty_oe: got %0d bursts want 0", cap_oe.size());
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] hand;
    ch_mask = 4'b0001; nbits = 5'd8; word = 24'hFFFFA5; line_period = 16'd16;
    hand = 8'b10100101;   // expected order 1,0,1,0,0,1,0,1 read left to right
    exp_q.delete();
    for (int i = 7; i >= 0; i--) exp_q.push_back(hand[i]);
    do_start(1'b1);
    capture(400, 1'b0);
    n_cmp++;
    if ((cap_lens.size() !== 1) || (cap_end_cyc !== 171)) begin
      n_bad++; $display("FAIL lsb_burst: got %0d bursts end %0d want 1/171", cap_lens.size(), cap_end_cyc);
    end else begin
      n_cmp++;
      if (cap_lens[0] !== 152) begin
        n_bad++; $display("FAIL lsb_len: got %0d want 152", cap_lens[0]);
      end
    end
    n_cmp++;
    if (cap_bits.size() !== 8) begin
      n_bad++; $display("FAIL lsb_bit_count: got %0d want 8", cap_bits.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_cmp++;
        if (cap_bits[i] !== exp_q[i]) begin
          n_bad++; $display("FAIL lsb_bit%0d: got %b want %b", i, cap_bits[i], exp_q[i]);
        end
      end
    end
    use_lsb = 1'b0;
  endtask

  task automatic test_boundaries();
    // NBITS=0 with zero gap
    ch_mask = 4'b0001; nbits = 5'd0; word = 24'hAEC9EC; line_period = 16'd0;
    do_start(1'b0);
    capture(1000, 1'b0);
    n_cmp++;
    if ((cap_end_cyc !== 460) || (cap_lens.size() !== 1)) begin
      n_bad++; $display("FAIL nbits0_end: got end %0d bursts %0d want 460/1", cap_end_cyc, cap_lens.size());
    end else begin
      n_cmp++;
      if ((cap_gaps[0] !== 1) || (cap_lens[0] !== 456)) begin
        n_bad++; $display("FAIL nbits0_gap_len: got %0d/%0d want 1/456", cap_gaps[0], cap_lens[0]);
      end
    end
    // NBITS above maximum clamps to full width
    nbits = 5'd31; line_period = 16'd1;
    do_start(1'b0);
    capture(1000, 1'b0);
    n_cmp++;
    if ((cap_lens.size() !== 1) || (cap_bits.size() !== 24)) begin
      n_bad++; $display("FAIL nbits31: got %0d bursts %0d bits want 1/24", cap_lens.size(), cap_bits.size());
    end else begin
      n_cmp++;
      if ((cap_lens[0] !== 456) || (cap_gaps[0] !== 1)) begin
        n_bad++; $display("FAIL nbits31_len_gap: got %0d/%0d want 456/1", cap_lens[0], cap_gaps[0]);
      end
    end
    // Single bit burst on channel 3
    ch_mask = 4'b1000; nbits = 5'd1; word = 24'h000001; line_period = 16'd2;
    do_start(1'b0);
    capture(200, 1'b0);
    n_cmp++;
    if ((cap_end_cyc !== 24) || (cap_bits.size() !== 1) || (cap_lens.size() !== 1)) begin
      n_bad++; $display("FAIL nbits1: got end %0d bits %0d bursts %0d want 24/1/1",
                        cap_end_cyc, cap_bits.size(), cap_lens.size());
    end else begin
      n_cmp++;
      if ({cap_bits[0], cap_oe[0], cap_ch[0], 5'(cap_lens[0])} !== {1'b1, 4'b1000, 4'd3, 5'd19}) begin
        n_bad++; $display("FAIL nbits1_burst: got bit %b oe %b ch %0d len %0d want 1 1000 3 19",
                          cap_bits[0], cap_oe[0], cap_ch[0], cap_lens[0]);
      end
    end
  endtask

  task automatic test_start_held();
    ch_mask = 4'b0001; nbits = 5'd24; word = 24'h5A5A5A; line_period = 16'd100;
    do_start(1'b0);
    fork
      capture(1200, 1'b1);
      begin
        repeat (479) @(negedge clk);
        start_m = 1'b0;
        repeat (5) @(negedge clk);
        start_m = 1'b1;     // second edge lands mid-burst
        repeat (115) @(negedge clk);
        start_m = 1'b0;
      end
    join
    n_cmp++;
    if ((cap_end_cnt !== 1) || (cap_end_cyc !== 559)) begin
      n_bad++; $display("FAIL held_end: got cnt %0d cyc %0d want 1/559", cap_end_cnt, cap_end_cyc);
    end
    n_cmp++;
    if ((cap_busy_rises !== 1) || (cap_lens.size() !== 1)) begin
      n_bad++; $display("FAIL held_transfers: got rises %0d bursts %0d want 1/1", cap_busy_rises, cap_lens.size());
    end
  endtask

  task automatic test_reset_mid();
    int seen_shift, ends;
    logic [23:0] got;
    ch_mask = 4'b0001; nbits = 5'd24; word = 24'hAEC9EC; line_period = 16'd20;
    do_start(1'b0);
    seen_shift = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (st_m == ST_SHIFT) begin
        seen_shift = 1;
        break;
      end
    end
    n_cmp++;
    if (seen_shift !== 1) begin
      n_bad++; $display("FAIL mid_reach_shift: got %0d want 1", seen_shift);
    end
    repeat (10 * 19 + 4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy_m, end_m, tclk_m, tdat_m, oe_m, ch_m} !== 12'd0) begin
      n_bad++; $display("FAIL mid_reset_outputs: got %b want 0", {busy_m, end_m, tclk_m, tdat_m, oe_m, ch_m});
    end
    rst_n = 1'b1;
    ends = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (end_m || busy_m) ends++;
    end
    n_cmp++;
    if (ends !== 0) begin
      n_bad++; $display("FAIL mid_no_end: got %0d end/busy cycles want 0", ends);
    end
    do_start(1'b0);
    capture(1000, 1'b0);
    n_cmp++;
    if ((cap_end_cnt !== 1) || (cap_bits.size() !== 24)) begin
      n_bad++; $display("FAIL mid_rerun: got end %0d bits %0d want 1/24", cap_end_cnt, cap_bits.size());
    end else begin
      for (int i = 0; i < 24; i++) got[23 - i] = cap_bits[i];
      n_cmp++;
      if (got !== 24'hAEC9EC) begin
        n_bad++; $display("FAIL mid_rerun_bits: got %h want aec9ec", got);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_two_channels();
    test_empty_mask();
    test_lsb_first();
    test_boundaries();
    test_start_held();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/config_tx_mc.md
CONFIG_TX_MC -- requirements
Module: config_tx_mc

Interface
REQ-001 Parameter CLOCK_PERIOD_PS, default 20833: system clock period in ps (48 MHz).
REQ-002 Parameter BIT_PERIOD_NS, default 400: serial bit period in ns (2.5 MHz).
REQ-003 Parameter C_NO_CFG_BITS, default 24: maximum configuration word width.
REQ-004 Parameter C_NO_CHANNELS, default 4: number of sensor channels, range 1..16.
REQ-005 Parameter C_MSB_FIRST, default 1: 1 = MSB-first shifting, 0 = LSB-first.
REQ-006 CLOCK  in  1  system clock; sole clock, all logic on its rising edge.
REQ-007 RESET_N  in  1  reset, synchronous, active-low.
REQ-008 START  in  1  transfer request, rising-edge detected.
REQ-009 CH_MASK  in  C_NO_CHANNELS  channels to configure, sampled at accepted START.
REQ-010 NBITS  in  clog2(C_NO_CFG_BITS+1)  bits per transfer, sampled at accepted START.
REQ-011 INPUT  in  C_NO_CFG_BITS  configuration word; lowest NBITS bits used, sampled at accepted START.
REQ-012 LINE_PERIOD  in  16  idle gap in CLOCK cycles before each channel's burst.
REQ-013 BUSY  out  1  high from accepted START until TX_END.
REQ-014 TX_END  out  1  one-cycle pulse after the last masked channel completes.
REQ-015 TX_CLK  out  1  serial clock shared by all channels.
REQ-016 TX_DAT  out  1  serial data shared by all channels.
REQ-017 TX_OE  out  C_NO_CHANNELS  per-channel output enable, one-hot or zero.
REQ-018 CH_IDX  out  4  index of the channel currently served; 0 when idle.

Function
REQ-019 BIT_CYCLES SHALL equal floor(BIT_PERIOD_NS*1000/CLOCK_PERIOD_PS), 19 at defaults; elaboration SHALL fail if below 2.
REQ-020 Each bit: TX_CLK low for floor(BIT_CYCLES/2) cycles, then high for the remainder; TX_DAT changes only on the cycle TX_CLK goes low.
REQ-021 States: IDLE, LOAD, GAP, SHIFT, NEXT, DONE.
REQ-022 IDLE: START rising edge -> LOAD, latch CH_MASK/NBITS/INPUT, BUSY=1 next cycle.
REQ-023 LOAD: select lowest set mask bit -> GAP; mask zero -> DONE.
REQ-024 GAP: count LINE_PERIOD cycles, TX_OE all zero; LINE_PERIOD=0 -> SHIFT next cycle.
REQ-025 SHIFT: TX_OE[CH_IDX]=1; send NBITS bits of latched word (bit NBITS-1 first if C_MSB_FIRST, else bit 0 first); lasts exactly NBITS*BIT_CYCLES cycles.
REQ-026 NEXT: clear served mask bit; remaining bits -> GAP for next lowest channel, else -> DONE.
REQ-027 DONE: TX_END=1 for one cycle, BUSY=0 on same cycle, -> IDLE.
REQ-028 NBITS=0 or NBITS>C_NO_CFG_BITS SHALL be treated as C_NO_CFG_BITS.
REQ-029 START edges while BUSY SHALL be ignored; START held high SHALL yield one transfer only.
REQ-030 Outside SHIFT: TX_CLK=0, TX_DAT=0, TX_OE=0.
REQ-031 Bit counter and cycle counter widths SHALL derive from parameters via clog2; no wrap within a transfer.

Reset
REQ-032 RESET_N low at a rising edge: state IDLE, BUSY=0, TX_END=0, TX_CLK=0, TX_DAT=0, TX_OE=0, CH_IDX=0, counters and latched values cleared, START edge detector primed so a START already high is not treated as an edge.
REQ-033 Reset mid-transfer SHALL abort silently with no TX_END pulse.

Structure
REQ-034 State encoding and the BIT_CYCLES/counter-width functions SHALL reside in shared package config_tx_pkg.
REQ-035 One sub-module config_tx_bitgen (bit-timing counter generating TX_CLK phase and bit-strobe) is natural; the FSM and shifter reside in config_tx_mc.

Verification
REQ-036 Defaults, INPUT=24'hAEC9EC, NBITS=24, CH_MASK=4'b0001, LINE_PERIOD=4000 -> 4000 gap cycles, TX_OE=4'b0001 for 456 cycles, TX_DAT bits 1,0,1,0,1,1,1,0,... sampled at TX_CLK rises, then one TX_END pulse.
REQ-037 CH_MASK=4'b0101 -> channel 0 burst, 4000-cycle gap, channel 2 burst, CH_IDX 0 then 2, single TX_END after second burst.
REQ-038 CH_MASK=0 -> TX_END pulse within 3 cycles of START edge, TX_OE never asserted.
REQ-039 NBITS=8, INPUT=24'hFFFFA5, C_MSB_FIRST=0 -> 152-cycle burst, bits 1,0,1,0,0,1,0,1.
REQ-040 START held high 10 us, second START edge mid-burst -> exactly one transfer, one TX_END.
REQ-041 RESET_N low for 1 cycle during bit 10 -> next cycle all outputs zero, no TX_END; fresh START runs a full transfer.
